// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC flit field widths, field offsets and PE numbering helpers
package noc_pkg;
  localparam int X           = 4;
  localparam int Y           = 4;
  localparam int DEST_X      = 2;
  localparam int DEST_Y      = 2;
  localparam int SOURCE_X    = 8;
  localparam int SOURCE_Y    = 8;
  localparam int DATA_WIDTH  = 240;
  localparam int TOTAL_WIDTH = DEST_X + DEST_Y + SOURCE_X + SOURCE_Y + DATA_WIDTH;
  function automatic int off_dest_x();
    return 0;
  endfunction
  function automatic int off_dest_y();
    return DEST_X;
  endfunction
  function automatic int off_src_x();
    return DEST_X + DEST_Y;
  endfunction
  function automatic int off_src_y();
    return DEST_X + DEST_Y + SOURCE_X;
  endfunction
  function automatic int off_payload();
    return DEST_X + DEST_Y + SOURCE_X + SOURCE_Y;
  endfunction
  function automatic int pe_num(int x, int y);
    return y * X + x;
  endfunction
  // index width that stays at least one bit for a single requester
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/noc_inject_arbiter_if.sv
// noc_inject_arbiter_if: requester flits in, one registered flit out to the router local port
interface noc_inject_arbiter_if
  import noc_pkg::*;
#(parameter int NUM_REQ = 4);
  localparam int IW = idx_w(NUM_REQ);
  logic [NUM_REQ*TOTAL_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [TOTAL_WIDTH-1:0]         o_data;
  logic                           o_valid;
  logic                           i_ready;
  logic [IW-1:0]                  grant_idx;
  modport master (output req_data, req_valid, i_ready, input req_ready, o_data, o_valid, grant_idx);
  modport slave  (input req_data, req_valid, i_ready, output req_ready, o_data, o_valid, grant_idx);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker, scans ptr, ptr+1, ... mod N for the first request
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // scanning downward lets the closest request to ptr overwrite farther ones
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + i) % N);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: round-robin share of one router injection port among NUM_REQ PEs.
// Defining ARB_STATS_EN adds a 32-bit grant counter per requester readable via stat_sel.
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  noc_inject_arbiter_if.slave   bus,
  input  logic [IW-1:0]         stat_sel,
  output logic [31:0]           stat_count
);
  localparam int TW = TOTAL_WIDTH;
  logic               slot_free;
  logic               pick_any;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      grant_q;
  logic [TW-1:0]      o_data_q;
  logic               o_valid_q;
  assign slot_free = !o_valid_q || bus.i_ready;
  // nothing is offered while the slot is held or the block is in reset
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i (bus.req_valid & {NUM_REQ{slot_free & rstn}}),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );
  assign ptr_d         = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
  assign bus.req_ready = pick_gnt;
  assign bus.o_data    = o_data_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.grant_idx = grant_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
    end else if (slot_free) begin
      o_valid_q <= pick_any;
      if (pick_any) begin
        o_data_q <= bus.req_data[int'(pick_idx)*TW +: TW];
        grant_q  <= pick_idx;
        ptr_q    <= ptr_d;
      end
    end
  end
`ifdef ARB_STATS_EN
  logic [31:0] cnt_q [NUM_REQ];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (pick_any) begin
      cnt_q[pick_idx] <= cnt_q[pick_idx] + 32'd1;
    end
  end
  assign stat_count = (int'(stat_sel) < NUM_REQ) ? cnt_q[stat_sel] : '0;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb_noc_inject_arbiter: directed checks of round-robin order, hold, reset and flit integrity
module tb_noc_inject_arbiter;
  import noc_pkg::*;
  localparam int N  = 4;
  localparam int TW = TOTAL_WIDTH;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  stat_sel = '0;
  logic [31:0] stat_count;
  int n_chk = 0;
  int n_err = 0;
  noc_inject_arbiter_if #(.NUM_REQ(N)) bus ();
  noc_inject_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // PE k sits at (k%X, k/X) and targets ((x+1)%X, y); s tags the flit sequence number
  function automatic logic [TW-1:0] mk(int k, int s);
    logic [TW-1:0] f;
    f = '0;
    f[off_dest_x() +: DEST_X]   = DEST_X'((k % X + 1) % X);
    f[off_dest_y() +: DEST_Y]   = DEST_Y'(k / X);
    f[off_src_x()  +: SOURCE_X] = SOURCE_X'(k % X);
    f[off_src_y()  +: SOURCE_Y] = SOURCE_Y'(k / X);
    for (int w = 0; w < DATA_WIDTH / 16; w++)
      f[off_payload() + 16*w +: 16] = 16'(32'hA500 ^ (k << 12) ^ (s << 8) ^ w);
    return f;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_data(input int s);
    for (int k = 0; k < N; k++) bus.req_data[k*TW +: TW] = mk(k, s);
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    bus.req_valid = '0;
    bus.i_ready = 1'b0;
    step();
    step();
    chk("rst_vld", bus.o_valid, 0);
    chk("rst_dat", bus.o_data, 0);
    chk("rst_gnt", bus.grant_idx, 0);
    chk("rst_rdy", bus.req_ready, 0);
    rstn = 1'b1;
  endtask
  initial begin
    int sent [N];
    int rcv [N];
    int hs;
    logic [N-1:0]  acc;
    logic          h;
    logic [1:0]    g;
    logic [TW-1:0] d;
    bus.req_data = '0;
    bus.req_valid = '0;
    bus.i_ready = 1'b0;
    // all requesters busy: strict rotation, one flit per cycle
    do_reset();
    set_data(0);
    bus.req_valid = 4'b1111;
    bus.i_ready = 1'b1;
    #1;
    chk("s1_rdy0", bus.req_ready, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("s1_vld", bus.o_valid, 1);
      chk("s1_gnt", bus.grant_idx, i % 4);
      chk("s1_dat", bus.o_data, mk(i % 4, 0));
      chk("s1_rdy", bus.req_ready, 4'b0001 << ((i + 1) % 4));
    end
    // backpressure holds the flit and blocks new accepts
    do_reset();
    set_data(1);
    bus.req_valid = 4'b0100;
    bus.i_ready = 1'b1;
    #1;
    chk("s2_rdy", bus.req_ready, 4'b0100);
    step();
    chk("s2_vld", bus.o_valid, 1);
    chk("s2_gnt", bus.grant_idx, 2);
    chk("s2_dat", bus.o_data, mk(2, 1));
    bus.i_ready = 1'b0;
    bus.req_data[2*TW +: TW] = mk(2, 2);
    #1;
    chk("s2_blk", bus.req_ready, 0);
    repeat (5) begin
      step();
      chk("s2_hold_dat", bus.o_data, mk(2, 1));
      chk("s2_hold_vld", bus.o_valid, 1);
      chk("s2_hold_rdy", bus.req_ready, 0);
    end
    bus.i_ready = 1'b1;
    #1;
    chk("s2_res_rdy", bus.req_ready, 4'b0100);
    step();
    chk("s2_res_dat", bus.o_data, mk(2, 2));
    chk("s2_res_vld", bus.o_valid, 1);
    // ptr=3 with requests 0 and 2: wraps to 0, then 2, leaving ptr at 3
    do_reset();
    set_data(3);
    bus.req_valid = 4'b0100;
    bus.i_ready = 1'b1;
    step();
    bus.req_valid = 4'b0101;
    #1;
    chk("s3_rdy_a", bus.req_ready, 4'b0001);
    step();
    chk("s3_gnt_a", bus.grant_idx, 0);
    chk("s3_rdy_b", bus.req_ready, 4'b0100);
    step();
    chk("s3_gnt_b", bus.grant_idx, 2);
    bus.req_valid = 4'b1111;
    #1;
    chk("s3_ptr", bus.req_ready, 4'b1000);
    bus.req_valid = '0;
    // reset while a flit is stalled drops it and rewinds ptr
    do_reset();
    set_data(4);
    bus.req_valid = 4'b0001;
    bus.i_ready = 1'b0;
    step();
    chk("s4_vld", bus.o_valid, 1);
    bus.req_valid = 4'b1111;
    rstn = 1'b0;
    #1;
    chk("s4_rst_rdy", bus.req_ready, 0);
    step();
    chk("s4_drop_vld", bus.o_valid, 0);
    chk("s4_drop_dat", bus.o_data, 0);
    bus.req_valid = '0;
    bus.i_ready = 1'b1;
    step();
    chk("s4_no_flit", bus.o_valid, 0);
    rstn = 1'b1;
    bus.req_valid = 4'b0011;
    #1;
    chk("s4_ptr", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    // each PE sends three flits; router stalls one cycle in four
    do_reset();
    hs = 0;
    for (int k = 0; k < N; k++) begin
      sent[k] = 0;
      rcv[k] = 0;
    end
    for (int c = 0; c < 200 && hs < 12; c++) begin
      for (int k = 0; k < N; k++) begin
        bus.req_data[k*TW +: TW] = mk(k, 10 + sent[k]);
        bus.req_valid[k] = sent[k] < 3;
      end
      bus.i_ready = (c % 4) != 3;
      #1;
      acc = bus.req_valid & bus.req_ready;
      h = bus.o_valid & bus.i_ready;
      g = bus.grant_idx;
      d = bus.o_data;
      step();
      for (int k = 0; k < N; k++) if (acc[k]) sent[k]++;
      if (h) begin
        chk("s5_flit", d, mk(int'(g), 10 + rcv[g]));
        rcv[g]++;
        hs++;
      end
    end
    bus.req_valid = '0;
    chk("s5_hs", hs, 12);
    for (int k = 0; k < N; k++) chk("s5_per_pe", rcv[k], 3);
    // 40 back-to-back accepts spread evenly over four requesters
    do_reset();
    set_data(0);
    bus.req_valid = 4'b1111;
    bus.i_ready = 1'b1;
    repeat (40) step();
    bus.req_valid = '0;
    for (int k = 0; k < N; k++) begin
      stat_sel = 2'(k);
      #1;
`ifdef ARB_STATS_EN
      chk("s6_stat", stat_count, 10);
`else
      chk("s6_stat", stat_count, 0);
`endif
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
